// File: rtl/inst_mem_pkg.sv
// Shared types and address checks for the instruction memory path.
// Used by the RAM arbiter and by the fetch stage.
package inst_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDW,
    ST_FERR,
    ST_WR
  } state_e;

  function automatic logic addr_in_range(
    input logic [31:0] a,
    input int unsigned aw
  );
    return (a >> aw) == 32'd0;
  endfunction

  function automatic logic fetch_addr_ok(
    input logic [31:0] a,
    input int unsigned aw
  );
    return (a[1:0] == 2'b00) && addr_in_range(a, aw);
  endfunction

endpackage

// File: rtl/inst_byte_ram.sv
// Single-port byte-wide instruction RAM with synchronous read.
// Read data shows the old contents when written in the same cycle.
module inst_byte_ram
  import inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares the byte RAM between 32-bit fetch reads and loader byte writes.
// Faulting addresses are answered without touching the RAM.
module inst_mem_arbiter
  import inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              F_REQ,
  input  logic [31:0]       F_ADDR,
  output logic              F_RDY,
  output logic              F_VALID,
  output logic [31:0]       F_DATA,
  output logic              F_ERR,
  input  logic              L_REQ,
  input  logic [31:0]       L_ADDR,
  input  logic [7:0]        L_DATA,
  output logic              L_ACK,
  output logic              L_ERR,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic              M_WE,
  output logic [7:0]        M_DI,
  input  logic [7:0]        M_DO
);

  localparam logic [1:0] K_LAST = 2'(WORD_BYTES - 1);

  state_e              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [7:0]          m_di_q, m_di_d;
  logic                wr_ok_q, wr_ok_d;
  logic [23:0]         asm_q, asm_d;
  logic [31:0]         f_data_q, f_data_d;
  logic                f_valid_q, f_valid_d;
  logic                f_err_q, f_err_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    m_addr_d  = m_addr_q;
    m_di_d    = m_di_q;
    wr_ok_d   = wr_ok_q;
    asm_d     = asm_q;
    f_data_d  = f_data_q;
    f_valid_d = 1'b0;
    f_err_d   = f_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (L_REQ) begin
          state_d  = ST_WR;
          m_addr_d = L_ADDR[ADDR_W-1:0];
          m_di_d   = L_DATA;
          wr_ok_d  = addr_in_range(L_ADDR, ADDR_W);
        end else if (F_REQ) begin
          if (fetch_addr_ok(F_ADDR, ADDR_W)) begin
            state_d  = ST_RD;
            k_d      = 2'd0;
            m_addr_d = F_ADDR[ADDR_W-1:0];
          end else begin
            state_d = ST_FERR;
          end
        end
      end
      ST_RD: begin
        // M_DO carries the byte addressed one cycle earlier
        case (k_q)
          2'd1:    asm_d[7:0]   = M_DO;
          2'd2:    asm_d[15:8]  = M_DO;
          2'd3:    asm_d[23:16] = M_DO;
          default: ;
        endcase
        if (k_q == K_LAST) begin
          state_d = ST_RDW;
        end else begin
          k_d      = k_q + 2'd1;
          m_addr_d = m_addr_q + ADDR_W'(1);
        end
      end
      ST_RDW: begin
        f_data_d  = {M_DO, asm_q};
        f_valid_d = 1'b1;
        f_err_d   = 1'b0;
        k_d       = 2'd0;
        state_d   = ST_IDLE;
      end
      ST_FERR: begin
        f_valid_d = 1'b1;
        f_err_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      k_q       <= 2'd0;
      m_addr_q  <= '0;
      m_di_q    <= 8'd0;
      wr_ok_q   <= 1'b0;
      asm_q     <= 24'd0;
      f_data_q  <= 32'd0;
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      m_addr_q  <= m_addr_d;
      m_di_q    <= m_di_d;
      wr_ok_q   <= wr_ok_d;
      asm_q     <= asm_d;
      f_data_q  <= f_data_d;
      f_valid_q <= f_valid_d;
      f_err_q   <= f_err_d;
    end
  end

  assign F_RDY   = (state_q == ST_IDLE) & ~L_REQ;
  assign F_VALID = f_valid_q;
  assign F_DATA  = f_data_q;
  assign F_ERR   = f_err_q;
  assign L_ACK   = (state_q == ST_WR);
  assign L_ERR   = (state_q == ST_WR) & ~wr_ok_q;
  // reset landing on a write cycle must not corrupt the RAM
  assign M_WE    = (state_q == ST_WR) & wr_ok_q & RST_N;
  assign M_ADDR  = m_addr_q;
  assign M_DI    = m_di_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench: arbiter wired to the byte RAM, loader and fetch traffic.
// Expected words and timings are written out by hand below.
module tb_inst_mem_arbiter;

  localparam int unsigned AW = 7;

  logic          CLK;
  logic          RST_N;
  logic          F_REQ;
  logic [31:0]   F_ADDR;
  logic          F_RDY;
  logic          F_VALID;
  logic [31:0]   F_DATA;
  logic          F_ERR;
  logic          L_REQ;
  logic [31:0]   L_ADDR;
  logic [7:0]    L_DATA;
  logic          L_ACK;
  logic          L_ERR;
  logic [AW-1:0] M_ADDR;
  logic          M_WE;
  logic [7:0]    M_DI;
  logic [7:0]    M_DO;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_data = 32'd0;

  inst_mem_arbiter #(.ADDR_W(AW)) u_dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .F_REQ   (F_REQ),
    .F_ADDR  (F_ADDR),
    .F_RDY   (F_RDY),
    .F_VALID (F_VALID),
    .F_DATA  (F_DATA),
    .F_ERR   (F_ERR),
    .L_REQ   (L_REQ),
    .L_ADDR  (L_ADDR),
    .L_DATA  (L_DATA),
    .L_ACK   (L_ACK),
    .L_ERR   (L_ERR),
    .M_ADDR  (M_ADDR),
    .M_WE    (M_WE),
    .M_DI    (M_DI),
    .M_DO    (M_DO)
  );

  inst_byte_ram #(.ADDR_W(AW)) u_ram (
    .clk   (CLK),
    .addr  (M_ADDR),
    .we    (M_WE),
    .wdata (M_DI),
    .rdata (M_DO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // n byte writes with L_REQ held; WR every second cycle
  task automatic wr_burst(
    input logic [31:0] a,
    input logic [31:0] bytes_w,
    input int          n,
    input logic        exp_err
  );
    L_REQ = 1'b1;
    for (int i = 0; i < n; i++) begin
      L_ADDR = a + 32'(i);
      L_DATA = bytes_w[8*i +: 8];
      tick();
      check("wr_ack", {31'd0, L_ACK}, 32'd1);
      check("wr_err", {31'd0, L_ERR}, {31'd0, exp_err});
      check("wr_we", {31'd0, M_WE}, {31'd0, ~exp_err});
      check("wr_addr", 32'(M_ADDR), 32'(AW'(a + 32'(i))));
      check("wr_di", 32'(M_DI), 32'(bytes_w[8*i +: 8]));
      if (i == n - 1) L_REQ = 1'b0;
      tick();
      check("wr_gap_ack", {31'd0, L_ACK}, 32'd0);
      check("wr_gap_we", {31'd0, M_WE}, 32'd0);
    end
  endtask

  // starts in an IDLE cycle with L_REQ low
  task automatic fetch(
    input logic [31:0] a,
    input logic [31:0] exp_data,
    input logic        exp_err
  );
    logic [AW-1:0] addr0;
    F_REQ  = 1'b1;
    F_ADDR = a;
    #1;
    addr0 = M_ADDR;
    check("f_rdy0", {31'd0, F_RDY}, 32'd1);
    tick();
    F_REQ = 1'b0;
    if (exp_err) begin
      check("ferr_c1_valid", {31'd0, F_VALID}, 32'd0);
      check("ferr_c1_addr", 32'(M_ADDR), 32'(addr0));
      tick();
      check("ferr_valid", {31'd0, F_VALID}, 32'd1);
      check("ferr_err", {31'd0, F_ERR}, 32'd1);
      check("ferr_data", F_DATA, last_data);
      check("ferr_addr", 32'(M_ADDR), 32'(addr0));
      check("ferr_we", {31'd0, M_WE}, 32'd0);
    end else begin
      for (int c = 1; c <= 4; c++) begin
        check("f_maddr", 32'(M_ADDR), 32'(AW'(a + 32'(c - 1))));
        check("f_busy_valid", {31'd0, F_VALID}, 32'd0);
        tick();
      end
      check("f_c5_valid", {31'd0, F_VALID}, 32'd0);
      tick();
      check("f_valid", {31'd0, F_VALID}, 32'd1);
      check("f_err", {31'd0, F_ERR}, 32'd0);
      check("f_data", F_DATA, exp_data);
      check("f_rdy6", {31'd0, F_RDY}, 32'd1);
      last_data = exp_data;
    end
    tick();
    check("f_pulse_end", {31'd0, F_VALID}, 32'd0);
    check("f_data_hold", F_DATA, last_data);
  endtask

  initial begin
    RST_N  = 1'b0;
    F_REQ  = 1'b0;
    F_ADDR = 32'd0;
    L_REQ  = 1'b0;
    L_ADDR = 32'd0;
    L_DATA = 8'd0;
    tick();
    tick();
    check("rst_valid", {31'd0, F_VALID}, 32'd0);
    check("rst_err", {31'd0, F_ERR}, 32'd0);
    check("rst_data", F_DATA, 32'd0);
    check("rst_ack", {31'd0, L_ACK}, 32'd0);
    check("rst_lerr", {31'd0, L_ERR}, 32'd0);
    check("rst_we", {31'd0, M_WE}, 32'd0);
    check("rst_maddr", 32'(M_ADDR), 32'd0);
    check("rst_mdi", 32'(M_DI), 32'd0);
    RST_N = 1'b1;
    tick();
    check("rst_rdy", {31'd0, F_RDY}, 32'd1);

    wr_burst(32'h10, 32'h12345678, 4, 1'b0);
    fetch(32'h10, 32'h12345678, 1'b0);

    wr_burst(32'h20, 32'hDDCCBBAA, 4, 1'b0);
    fetch(32'h20, 32'hDDCCBBAA, 1'b0);

    // loader and fetch collide: write wins
    F_REQ  = 1'b1;
    F_ADDR = 32'h20;
    L_REQ  = 1'b1;
    L_ADDR = 32'h24;
    L_DATA = 8'h5A;
    #1;
    check("col_rdy0", {31'd0, F_RDY}, 32'd0);
    tick();
    check("col_we", {31'd0, M_WE}, 32'd1);
    check("col_waddr", 32'(M_ADDR), 32'h24);
    check("col_rdy1", {31'd0, F_RDY}, 32'd0);
    L_REQ = 1'b0;
    tick();
    fetch(32'h20, 32'hDDCCBBAA, 1'b0);

    wr_burst(32'h40, 32'h44332211, 4, 1'b0);

    fetch(32'h02, 32'd0, 1'b1);
    fetch(32'h80, 32'd0, 1'b1);
    wr_burst(32'h80, 32'h000000EE, 1, 1'b1);

    // reset during a write cycle
    L_REQ  = 1'b1;
    L_ADDR = 32'h40;
    L_DATA = 8'h99;
    tick();
    check("rwr_ack", {31'd0, L_ACK}, 32'd1);
    RST_N = 1'b0;
    L_REQ = 1'b0;
    #1;
    check("rwr_we", {31'd0, M_WE}, 32'd0);
    tick();
    RST_N = 1'b1;
    last_data = 32'd0;
    tick();
    fetch(32'h40, 32'h44332211, 1'b0);

    // reset in cycle 3 of a fetch
    F_REQ  = 1'b1;
    F_ADDR = 32'h10;
    tick();
    F_REQ = 1'b0;
    tick();
    tick();
    RST_N = 1'b0;
    tick();
    check("rf_valid", {31'd0, F_VALID}, 32'd0);
    check("rf_err", {31'd0, F_ERR}, 32'd0);
    check("rf_data", F_DATA, 32'd0);
    check("rf_maddr", 32'(M_ADDR), 32'd0);
    check("rf_mdi", 32'(M_DI), 32'd0);
    check("rf_we", {31'd0, M_WE}, 32'd0);
    check("rf_ack", {31'd0, L_ACK}, 32'd0);
    RST_N = 1'b1;
    last_data = 32'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rf_no_valid", {31'd0, F_VALID}, 32'd0);
    end
    fetch(32'h10, 32'h12345678, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
